// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, arbiter state encoding and pixel addressing helpers.
// Word address is {y, x[5:3]}; pixel n of a word lives in bits [4n+3:4n].
package fb_pkg;

  localparam int FB_W     = 64;
  localparam int FB_H     = 48;
  localparam int FB_WORDS = 384;

  localparam logic [5:0] FB_H_LIM = 6'(FB_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FILL = 2'd3
  } fb_state_t;

  // One buffered pixel write; exactly 16 bits so it maps onto the FIFO word.
  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [3:0] color;
  } wr_req_t;

  typedef struct packed {
    logic [8:0] word;
    logic [2:0] nib;
  } pix_loc_t;

  function automatic pix_loc_t fb_locate(input logic [5:0] x, input logic [5:0] y);
    pix_loc_t loc;
    loc.word = {y, x[5:3]};
    loc.nib  = x[2:0];
    return loc;
  endfunction

  function automatic logic [31:0] nib_merge(input logic [31:0] word,
                                            input logic [2:0]  nib,
                                            input logic [3:0]  val);
    logic [31:0] w;
    w = word;
    w[{nib, 2'b00} +: 4] = val;
    return w;
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Display, pixel-write, fill and RAM port signals of the framebuffer arbiter.
// master = surrounding logic (feeder, drawing client, RAM); slave = the arbiter.
interface fb_arbiter_if;

  logic        disp_rd;
  logic        disp_row;
  logic [8:0]  disp_addr;
  logic [2:0]  disp_pix_sel;
  logic [3:0]  disp_pixel;

  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_x;
  logic [5:0]  wr_y;
  logic [3:0]  wr_color;

  logic        fill_start;
  logic [3:0]  fill_color;
  logic        busy;

  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output disp_rd, disp_row, disp_addr, disp_pix_sel,
    output wr_valid, wr_x, wr_y, wr_color,
    output fill_start, fill_color,
    output mem_rdata,
    input  disp_pixel, wr_ready, busy, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  disp_rd, disp_row, disp_addr, disp_pix_sel,
    input  wr_valid, wr_x, wr_y, wr_color,
    input  fill_start, fill_color,
    input  mem_rdata,
    output disp_pixel, wr_ready, busy, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO for pending pixel writes; head word visible combinationally, push visible next cycle.
// Registered full/empty flags; push while full and pop while empty are ignored.
module fb_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_25,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_25) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win; pixel writes are 2-cycle RMWs (3 cycles accept->mem_we).
// Write client backpressured by wr_ready (FIFO full or reset); every disp_rd cycle stalls the engine one cycle.
module fb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int FB_WORDS   = 384
) (
  input logic        clk_25,
  input logic        rst_n,
  fb_arbiter_if.slave bus
);

  import fb_pkg::*;

  localparam logic [8:0] FILL_LAST = 9'(FB_WORDS - 1);

  fb_state_t   state_q;
  fb_state_t   state_d;

  logic        fill_pend_q;
  logic [3:0]  fill_color_q;
  logic [8:0]  fill_addr_q;
  logic [8:0]  fill_addr_d;
  logic        fill_done;

  logic [31:0] word_q;
  logic        word_ld;
  pix_loc_t    work_loc_q;
  logic [3:0]  work_color_q;
  logic        work_ld;

  wr_req_t     fifo_in;
  wr_req_t     fifo_head;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  pix_loc_t    head_loc;
  logic        head_ok;

  logic [8:0]  eng_addr;
  logic        eng_we;
  logic [31:0] eng_wdata;

  assign bus.wr_ready = rst_n && !fifo_full;
  assign fifo_push    = bus.wr_valid && bus.wr_ready;
  assign fifo_in      = '{x: bus.wr_x, y: bus.wr_y, color: bus.wr_color};

  fb_wr_fifo #(
    .WIDTH ($bits(wr_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_25   (clk_25),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (fifo_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Off-screen rows are still popped, just never turned into a memory access.
  assign head_loc = fb_locate(fifo_head.x, fifo_head.y);
  assign head_ok  = (fifo_head.y < FB_H_LIM);

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_done   = 1'b0;
    fifo_pop    = 1'b0;
    work_ld     = 1'b0;
    word_ld     = 1'b0;
    eng_addr    = 9'd0;
    eng_we      = 1'b0;
    eng_wdata   = 32'd0;

    case (state_q)
      IDLE: begin
        if (fill_pend_q && !bus.disp_row) begin
          state_d     = FILL;
          fill_addr_d = 9'd0;
        end else if (!fifo_empty && !bus.disp_row) begin
          fifo_pop = 1'b1;
          work_ld  = 1'b1;
          state_d  = head_ok ? RD : IDLE;
        end
      end

      RD: begin
        eng_addr = work_loc_q.word;
        if (!bus.disp_rd) begin
          word_ld = 1'b1;
          state_d = WR;
        end
      end

      // word_q stays valid across display stalls: the display path never writes.
      WR: begin
        eng_addr  = work_loc_q.word;
        eng_wdata = nib_merge(word_q, work_loc_q.nib, work_color_q);
        if (!bus.disp_rd) begin
          eng_we = 1'b1;
          if (!fifo_empty && !bus.disp_row && !fill_pend_q) begin
            fifo_pop = 1'b1;
            work_ld  = 1'b1;
            state_d  = head_ok ? RD : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      FILL: begin
        eng_addr  = fill_addr_q;
        eng_wdata = {8{fill_color_q}};
        if (!bus.disp_rd && !bus.disp_row) begin
          eng_we = 1'b1;
          if (fill_addr_q == FILL_LAST) begin
            fill_done   = 1'b1;
            fill_addr_d = 9'd0;
            state_d     = IDLE;
          end else begin
            fill_addr_d = fill_addr_q + 9'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fill_pend_q  <= 1'b0;
      fill_color_q <= 4'd0;
      fill_addr_q  <= 9'd0;
      word_q       <= 32'd0;
      work_loc_q   <= '0;
      work_color_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      if (word_ld) begin
        word_q <= bus.mem_rdata;
      end
      if (work_ld) begin
        work_loc_q   <= head_loc;
        work_color_q <= fifo_head.color;
      end
      if (fill_done) begin
        fill_pend_q <= 1'b0;
      end else if (bus.fill_start && !fill_pend_q) begin
        fill_pend_q  <= 1'b1;
        fill_color_q <= bus.fill_color;
      end
    end
  end

  // The reset gate keeps a half-finished RMW or fill from writing in the reset cycle.
  assign bus.mem_addr   = bus.disp_rd ? bus.disp_addr : eng_addr;
  assign bus.mem_we     = rst_n && !bus.disp_rd && eng_we;
  assign bus.mem_wdata  = eng_wdata;
  assign bus.disp_pixel = bus.mem_rdata[{bus.disp_pix_sel, 2'b00} +: 4];
  assign bus.busy       = fill_pend_q || (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: a RAM model answers reads; expected RAM writes are queued
// by the stimulus and a negedge monitor compares every mem_we against the queue head.
module tb_fb_arbiter;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk_25;
  logic        rst_n;
  int          cyc;
  int          n_checks;
  int          n_errors;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] ram [512];

  fb_arbiter_if bus ();

  fb_arbiter #(
    .FIFO_DEPTH (4),
    .FB_WORDS   (384)
  ) dut (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk_25 = 1'b0;
    forever #5 clk_25 = ~clk_25;
  end

  initial cyc = 0;
  always @(posedge clk_25) cyc <= cyc + 1;

  // RAM model: combinational read, write on the clock edge, known contents after every reset.
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk_25) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) ram[i] <= 32'd0;
      ram[25]  <= 32'h12345678;
      ram[100] <= 32'hFEDCBA98;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(negedge clk_25) begin
    if (bus.mem_we !== 1'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data %08h at cycle %0d, expected no write",
                 bus.mem_addr, bus.mem_wdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.mem_addr !== mon_e.addr || bus.mem_wdata !== mon_e.data ||
            (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
          n_errors++;
          $display("FAIL wr_commit: got addr %0d data %08h cycle %0d, expected addr %0d data %08h cycle %0d",
                   bus.mem_addr, bus.mem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk_25);
      #1;
    end
  endtask

  task automatic write_px(input logic [5:0] x, input logic [5:0] y, input logic [3:0] c,
                          output int acc);
    bus.wr_valid = 1'b1;
    bus.wr_x     = x;
    bus.wr_y     = y;
    bus.wr_color = c;
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk_25);
      if (bus.wr_ready === 1'b1) acc = cyc;
      @(posedge clk_25);
      #1;
    end
    bus.wr_valid = 1'b0;
    if (acc < 0) chk("wr_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_wait();
    repeat (4) @(posedge clk_25);
    #1;
    @(negedge clk_25);
    chk("idle_busy", bus.busy, 1'b0);
    @(posedge clk_25);
    #1;
  endtask

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: still running at %0t, expected end well before", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int d;
    int f;
    n_checks = 0;
    n_errors = 0;
    rst_n            = 1'b0;
    bus.disp_rd      = 1'b0;
    bus.disp_row     = 1'b0;
    bus.disp_addr    = 9'd0;
    bus.disp_pix_sel = 3'd0;
    bus.wr_valid     = 1'b0;
    bus.wr_x         = 6'd0;
    bus.wr_y         = 6'd0;
    bus.wr_color     = 4'd0;
    bus.fill_start   = 1'b0;
    bus.fill_color   = 4'd0;

    // Reset held for three edges.
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_wr_ready", bus.wr_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge clk_25);
    #1;
    rst_n = 1'b1;
    @(negedge clk_25);
    chk("post_rst_wr_ready", bus.wr_ready, 1'b1);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("idle_mem_addr", bus.mem_addr, 9'd0);
    @(posedge clk_25);
    #1;

    // Single write x=10 y=3 -> word 25 nibble 2.
    write_px(6'd10, 6'd3, 4'hA, acc);
    sb.push_back('{9'd25, 32'h12345A78, acc + 3});
    goto_cyc(acc + 2);
    @(negedge clk_25);
    chk("rd_mem_addr", bus.mem_addr, 9'd25);
    chk("rd_mem_we", bus.mem_we, 1'b0);
    idle_wait();

    // Collision: display read lands on the WR cycle and pushes the commit out by one.
    write_px(6'd13, 6'd3, 4'hC, acc);
    sb.push_back('{9'd25, 32'h12C45A78, acc + 4});
    goto_cyc(acc + 3);
    bus.disp_rd      = 1'b1;
    bus.disp_addr    = 9'd100;
    bus.disp_pix_sel = 3'd3;
    @(negedge clk_25);
    chk("coll_mem_addr", bus.mem_addr, 9'd100);
    chk("coll_mem_we", bus.mem_we, 1'b0);
    chk("coll_pixel_sel3", bus.disp_pixel, 4'hB);
    #1;
    bus.disp_pix_sel = 3'd6;
    #1;
    chk("coll_pixel_sel6", bus.disp_pixel, 4'hE);
    @(posedge clk_25);
    #1;
    bus.disp_rd = 1'b0;
    idle_wait();

    // FIFO full behind disp_row, then drain in order two cycles apart.
    bus.disp_row = 1'b1;
    write_px(6'd0,  6'd0,  4'h1, acc);
    write_px(6'd63, 6'd47, 4'hF, acc);
    write_px(6'd9,  6'd0,  4'h2, acc);
    write_px(6'd1,  6'd0,  4'h3, acc);
    bus.wr_valid = 1'b1;
    bus.wr_x     = 6'd2;
    bus.wr_y     = 6'd2;
    bus.wr_color = 4'h7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25);
      chk("full_wr_ready", bus.wr_ready, 1'b0);
      @(posedge clk_25);
      #1;
    end
    bus.wr_valid = 1'b0;
    d = cyc;
    bus.disp_row = 1'b0;
    sb.push_back('{9'd0,   32'h00000001, d + 2});
    sb.push_back('{9'd383, 32'hF0000000, d + 4});
    sb.push_back('{9'd1,   32'h00000020, d + 6});
    sb.push_back('{9'd0,   32'h00000031, d + 8});
    goto_cyc(d + 9);
    @(negedge clk_25);
    chk("drain_busy", bus.busy, 1'b0);
    chk("drain_wr_ready", bus.wr_ready, 1'b1);
    @(posedge clk_25);
    #1;

    // Off-screen row: accepted, popped, dropped.
    write_px(6'd5, 6'd50, 4'h3, acc);
    @(negedge clk_25);
    chk("oor_busy_pop", bus.busy, 1'b1);
    @(posedge clk_25);
    #1;
    @(negedge clk_25);
    chk("oor_busy_done", bus.busy, 1'b0);
    @(posedge clk_25);
    #1;

    // Reset landing on the WR cycle: no write, state cleared.
    write_px(6'd0, 6'd1, 4'h9, acc);
    goto_cyc(acc + 3);
    rst_n = 1'b0;
    @(negedge clk_25);
    chk("midrst_mem_we", bus.mem_we, 1'b0);
    chk("midrst_wr_ready", bus.wr_ready, 1'b0);
    @(posedge clk_25);
    #1;
    @(negedge clk_25);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_mem_addr", bus.mem_addr, 9'd0);
    @(posedge clk_25);
    #1;
    rst_n = 1'b1;
    idle_wait();

    // Fill with 0x5, a repeated fill_start mid-way, and 10 disp_row stall cycles.
    f = cyc;
    bus.fill_color = 4'h5;
    bus.fill_start = 1'b1;
    for (int i = 0; i < 384; i++) begin
      sb.push_back('{9'(i), 32'h55555555, (i == 383) ? f + 395 : -1});
    end
    @(posedge clk_25);
    #1;
    bus.fill_start = 1'b0;
    goto_cyc(f + 50);
    bus.fill_color = 4'hA;
    bus.fill_start = 1'b1;
    @(posedge clk_25);
    #1;
    bus.fill_start = 1'b0;
    goto_cyc(f + 100);
    for (int i = 0; i < 20; i++) begin
      bus.disp_row = (i % 2 == 0);
      @(posedge clk_25);
      #1;
    end
    bus.disp_row = 1'b0;
    goto_cyc(f + 395);
    @(negedge clk_25);
    chk("fill_busy_last", bus.busy, 1'b1);
    @(posedge clk_25);
    #1;
    @(negedge clk_25);
    chk("fill_busy_after", bus.busy, 1'b0);
    repeat (3) @(posedge clk_25);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
